fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage MIPS32 pipeline. It owns the program counter and drives the chip-enable and byte address of the combinational instruction ROM. It captures the returned word into the IF/ID pipeline register for the decode stage. It also handles stall, pipeline flush/redirect, ID-resolved branches (with architectural delay slot) and misaligned-target address faults.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; first fetched address.
- EXC_VECTOR, 32'h0000_0100, redirect address on a misaligned branch target.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- stall  input  1  hold PC and IF/ID contents.
- flush  input  1  squash IF/ID and redirect PC to flush_pc (from exception logic).
- flush_pc  input  32  redirect target when flush=1.
- branch_en  input  1  taken branch/jump resolved in ID this cycle.
- branch_target  input  32  byte address of branch destination.
- rom_instr  input  32  instruction word returned by ROM for rom_addr (same cycle).
- rom_ce  output  1  ROM chip enable.
- rom_addr  output  32  fetch byte address (= PC); ROM indexes addr[9:2].
- id_pc  output  32  PC of instruction held in IF/ID.
- id_instr  output  32  instruction held in IF/ID (32'h0 = NOP/bubble).
- id_valid  output  1  IF/ID holds a real instruction.
- fetch_exc  output  1  one-cycle pulse: misaligned branch target detected.
- exc_epc  output  32  offending branch_target, latched with fetch_exc.

## Operation
- States: IDLE, RUN. Reset forces IDLE. The first rising edge with rst_n=1 moves IDLE->RUN. RUN is left only by reset.
- In IDLE: rom_ce=0, PC held at RESET_PC, IF/ID loads bubble (id_instr=0, id_valid=0, id_pc=0).
- In RUN: rom_ce=1, rom_addr=PC combinationally.
- PC update priority in RUN, highest first:
  - flush: PC<=flush_pc.
  - stall: PC held; branch_en ignored. ID holds branch_en while stalled.
  - branch_en with branch_target[1:0]!=0: PC<=EXC_VECTOR, fetch_exc<=1, exc_epc<=branch_target.
  - branch_en: PC<=branch_target.
  - otherwise: PC<=PC+4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID update priority in RUN, highest first:
  - flush: bubble.
  - stall: hold all fields.
  - otherwise: id_instr<=rom_instr, id_pc<=PC, id_valid<=1.
- Delay slot: on a taken branch the word fetched in the same cycle (PC+4 of the branch) still enters IF/ID; no squash.
- Misaligned fault: the delay-slot word is still captured. The EXC_VECTOR fetch follows.
- fetch_exc is high exactly one cycle; otherwise 0.
- exc_epc holds its value until the next fault or reset.
- flush and branch_en in the same cycle: flush wins and no fault is raised.
- The low two bits of flush_pc are not checked.

## Timing
- Reset values: PC=RESET_PC, rom_ce=0, id_pc=0, id_instr=0, id_valid=0, fetch_exc=0, exc_epc=0, state=IDLE.
- Reset mid-operation asynchronously forces all of the above immediately, independent of clk.
- Edge 1 after reset release: IDLE->RUN, PC stays RESET_PC. rom_ce=1 after this edge.
- Edge 2: IF/ID captures word at RESET_PC; PC<=RESET_PC+4.
- Fetch-to-ID latency: 1 cycle. Word at rom_addr in cycle n appears on id_instr after edge n+1.
- Branch redirect: branch_en sampled at edge n; rom_addr=branch_target in cycle n+1.
- Stall: outputs hold from the edge where stall=1 is sampled. Release resumes at the held PC with no word lost or duplicated.
- No combinational path from stall/flush/branch inputs to rom_addr; rom_addr is registered PC only.

## Test plan
- Reset/startup: ROM words 0..3 = 0x34229C98, 0x34430003, 0x34646000, 0x34850000; release rst_n. Required:
  - id_valid=0 for 2 edges.
  - id_instr then reads 0x34229C98, 0x34430003, 0x34646000, 0x34850000 on consecutive cycles, id_pc=0,4,8,12.
- Stall: assert stall 3 cycles while PC=8. Required:
  - rom_addr stays 8 and id_instr/id_pc hold.
  - After release, IF/ID shows PC=8 then 12 with no duplicate or gap.
- Branch + delay slot: branch_en=1, target 0x40 while fetching PC=0x10. Required:
  - IF/ID shows 0x10 (delay slot) then 0x40, 0x44.
- Misaligned target: branch_en=1, target 0x42. Required:
  - fetch_exc pulses 1 cycle, exc_epc=0x42.
  - Next fetch address 0x100.
- Flush priority: flush=1, flush_pc=0x80 with stall=1 and branch_en=1 (target 0x43) same cycle. Required:
  - Next cycle id_valid=0 and rom_addr=0x80.
  - fetch_exc stays 0.
- Async reset mid-run plus wrap:
  - Drop rst_n between edges during RUN. Required: rom_ce and id_valid go 0 immediately.
  - Separately, flush_pc=0xFFFFFFFC. Required: next addresses 0xFFFFFFFC then 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and
// fills the IF/ID register, with stall, flush, delayed branches and faults.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   input  logic [31:0] rom_instr,
   output logic        rom_ce,
   output logic [31:0] rom_addr,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic        fetch_exc,
   output logic [31:0] exc_epc
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_RUN  = 1'b1;

   logic        state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic        id_valid_q, id_valid_d;
   logic        fetch_exc_q, fetch_exc_d;
   logic [31:0] exc_epc_q, exc_epc_d;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      id_pc_d     = id_pc_q;
      id_instr_d  = id_instr_q;
      id_valid_d  = id_valid_q;
      fetch_exc_d = 1'b0;
      exc_epc_d   = exc_epc_q;

      if (state_q == S_IDLE) begin
         state_d    = S_RUN;
         pc_d       = RESET_PC;
         id_pc_d    = 32'h0;
         id_instr_d = 32'h0;
         id_valid_d = 1'b0;
      end else begin
         // Stall masks branch_en; ID keeps presenting it until released.
         if (flush) begin
            pc_d = flush_pc;
         end else if (stall) begin
            pc_d = pc_q;
         end else if (branch_en && (branch_target[1:0] != 2'b00)) begin
            pc_d        = EXC_VECTOR;
            fetch_exc_d = 1'b1;
            exc_epc_d   = branch_target;
         end else if (branch_en) begin
            pc_d = branch_target;
         end else begin
            pc_d = pc_q + 32'd4;
         end

         // The delay-slot word is captured even when a branch is taken.
         if (flush) begin
            id_pc_d    = 32'h0;
            id_instr_d = 32'h0;
            id_valid_d = 1'b0;
         end else if (!stall) begin
            id_pc_d    = pc_q;
            id_instr_d = rom_instr;
            id_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         id_pc_q     <= 32'h0;
         id_instr_q  <= 32'h0;
         id_valid_q  <= 1'b0;
         fetch_exc_q <= 1'b0;
         exc_epc_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         id_pc_q     <= id_pc_d;
         id_instr_q  <= id_instr_d;
         id_valid_q  <= id_valid_d;
         fetch_exc_q <= fetch_exc_d;
         exc_epc_q   <= exc_epc_d;
      end
   end

   assign rom_ce    = (state_q == S_RUN);
   assign rom_addr  = pc_q;
   assign id_pc     = id_pc_q;
   assign id_instr  = id_instr_q;
   assign id_valid  = id_valid_q;
   assign fetch_exc = fetch_exc_q;
   assign exc_epc   = exc_epc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, stall, delayed branch,
// misaligned fault, flush priority, PC wrap and asynchronous reset.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_en;
   logic [31:0] branch_target;
   logic [31:0] rom_instr;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        fetch_exc;
   logic [31:0] exc_epc;

   logic [31:0] mem [256];
   int pass_cnt;
   int total_cnt;

   fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .branch_en    (branch_en),
      .branch_target(branch_target),
      .rom_instr    (rom_instr),
      .rom_ce       (rom_ce),
      .rom_addr     (rom_addr),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_valid     (id_valid),
      .fetch_exc    (fetch_exc),
      .exc_epc      (exc_epc)
   );

   assign rom_instr = mem[rom_addr[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
      branch_en = 1'b0; branch_target = 32'h0;
      tick();
      tick();
      total_cnt++;
      if (rom_ce !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
          id_pc !== 32'h0 || fetch_exc !== 1'b0 || exc_epc !== 32'h0 ||
         rom_addr !== 32'h0)
         $display("FAIL reset_state: ce=%b v=%b instr=%h pc=%h exc=%b epc=%h addr=%h, need all 0",
                  rom_ce, id_valid, id_instr, id_pc, fetch_exc, exc_epc, rom_addr);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      total_cnt++;
      if (rom_ce !== 1'b1 || id_valid !== 1'b0 || rom_addr !== 32'h0)
         $display("FAIL startup_edge1: ce=%b v=%b addr=%h, need ce=1 v=0 addr=0",
                  rom_ce, id_valid, rom_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_valid !== 1'b1 || id_instr !== 32'h34229C98 || id_pc !== 32'h0)
         $display("FAIL startup_w0: v=%b instr=%h pc=%h, need 1 34229c98 0",
                  id_valid, id_instr, id_pc);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_instr !== 32'h34430003 || id_pc !== 32'h4 || rom_addr !== 32'h8)
         $display("FAIL startup_w1: instr=%h pc=%h addr=%h, need 34430003 4 8",
                  id_instr, id_pc, rom_addr);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (rom_addr !== 32'h8 || id_pc !== 32'h4 || id_instr !== 32'h34430003)
            $display("FAIL stall_hold%0d: addr=%h pc=%h instr=%h, need 8 4 34430003",
                     i, rom_addr, id_pc, id_instr);
         else pass_cnt++;
      end
      stall = 1'b0;
      tick();
      total_cnt++;
      if (id_pc !== 32'h8 || id_instr !== 32'h34646000 || id_valid !== 1'b1)
         $display("FAIL stall_rel0: pc=%h instr=%h v=%b, need 8 34646000 1",
                  id_pc, id_instr, id_valid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_pc !== 32'hC || id_instr !== 32'h34850000 || rom_addr !== 32'h10)
         $display("FAIL stall_rel1: pc=%h instr=%h addr=%h, need c 34850000 10",
                  id_pc, id_instr, rom_addr);
      else pass_cnt++;
   endtask

   task automatic test_branch();
      branch_en = 1'b1; branch_target = 32'h40;
      tick();
      branch_en = 1'b0;
      total_cnt++;
      if (id_pc !== 32'h10 || id_instr !== 32'hC0DE0004 || rom_addr !== 32'h40)
         $display("FAIL branch_slot: pc=%h instr=%h addr=%h, need 10 c0de0004 40",
                  id_pc, id_instr, rom_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_pc !== 32'h40 || id_instr !== 32'hC0DE0010)
         $display("FAIL branch_tgt: pc=%h instr=%h, need 40 c0de0010", id_pc, id_instr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_pc !== 32'h44 || id_instr !== 32'hC0DE0011 || rom_addr !== 32'h48)
         $display("FAIL branch_next: pc=%h instr=%h addr=%h, need 44 c0de0011 48",
                  id_pc, id_instr, rom_addr);
      else pass_cnt++;
   endtask

   task automatic test_misaligned();
      total_cnt++;
      if (fetch_exc !== 1'b0)
         $display("FAIL exc_idle: exc=%b, need 0", fetch_exc);
      else pass_cnt++;
      branch_en = 1'b1; branch_target = 32'h42;
      tick();
      branch_en = 1'b0;
      total_cnt++;
      if (fetch_exc !== 1'b1 || exc_epc !== 32'h42 || rom_addr !== 32'h100 ||
          id_pc !== 32'h48)
         $display("FAIL misalign_fault: exc=%b epc=%h addr=%h pc=%h, need 1 42 100 48",
                  fetch_exc, exc_epc, rom_addr, id_pc);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (fetch_exc !== 1'b0 || exc_epc !== 32'h42 || id_pc !== 32'h100 ||
          id_instr !== 32'hC0DE0040)
         $display("FAIL misalign_after: exc=%b epc=%h pc=%h instr=%h, need 0 42 100 c0de0040",
                  fetch_exc, exc_epc, id_pc, id_instr);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      flush = 1'b1; flush_pc = 32'h80; stall = 1'b1;
      branch_en = 1'b1; branch_target = 32'h43;
      tick();
      flush = 1'b0; stall = 1'b0; branch_en = 1'b0;
      total_cnt++;
      if (id_valid !== 1'b0 || id_instr !== 32'h0 || rom_addr !== 32'h80 ||
          fetch_exc !== 1'b0 || exc_epc !== 32'h42)
         $display("FAIL flush_prio: v=%b instr=%h addr=%h exc=%b epc=%h, need 0 0 80 0 42",
                  id_valid, id_instr, rom_addr, fetch_exc, exc_epc);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_instr !== 32'hC0DE0020 ||
          fetch_exc !== 1'b0)
         $display("FAIL flush_resume: v=%b pc=%h instr=%h exc=%b, need 1 80 c0de0020 0",
                  id_valid, id_pc, id_instr, fetch_exc);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0;
      total_cnt++;
      if (rom_addr !== 32'hFFFF_FFFC)
         $display("FAIL wrap_top: addr=%h, need fffffffc", rom_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'hC0DE00FF)
         $display("FAIL wrap_zero: addr=%h pc=%h instr=%h, need 0 fffffffc c0de00ff",
                  rom_addr, id_pc, id_instr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_pc !== 32'h0 || id_instr !== 32'h34229C98 || rom_addr !== 32'h4)
         $display("FAIL wrap_next: pc=%h instr=%h addr=%h, need 0 34229c98 4",
                  id_pc, id_instr, rom_addr);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (rom_ce !== 1'b0 || id_valid !== 1'b0 || rom_addr !== 32'h0 ||
          exc_epc !== 32'h0 || id_pc !== 32'h0)
         $display("FAIL async_rst: ce=%b v=%b addr=%h epc=%h pc=%h, need all 0",
                  rom_ce, id_valid, rom_addr, exc_epc, id_pc);
      else pass_cnt++;
      tick();
      rst_n = 1'b1;
      tick();
      total_cnt++;
      if (rom_ce !== 1'b1 || id_valid !== 1'b0 || rom_addr !== 32'h0)
         $display("FAIL rst_restart: ce=%b v=%b addr=%h, need 1 0 0",
                  rom_ce, id_valid, rom_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (id_valid !== 1'b1 || id_instr !== 32'h34229C98 || id_pc !== 32'h0)
         $display("FAIL rst_refetch: v=%b instr=%h pc=%h, need 1 34229c98 0",
                  id_valid, id_instr, id_pc);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[0] = 32'h34229C98;
      mem[1] = 32'h34430003;
      mem[2] = 32'h34646000;
      mem[3] = 32'h34850000;
      test_reset();
      test_stall();
      test_branch();
      test_misaligned();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
